// File: rtl/ring_rr_scheduler.sv
// ring_rr_scheduler
//   Round-robin scheduler sharing one resource between N requesters.
//   A one-hot rotating token marks the highest-priority requester; the
//   search for a winner runs circularly upward from the token bit. Each
//   tenure is bounded by a hold timer, and the token advances to the bit
//   just above the holder whenever a tenure ends.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   en           1 = new grants may be issued from IDLE
//   req[N]       level-sensitive request vector
//   done         holder releases the resource (only looked at in GRANT)
//   grant[N]     registered one-hot grant
//   grant_id     binary index of the holder (0 when idle)
//   busy         1 while in GRANT (this is also the FSM state bit)
//   token[N]     current one-hot priority pointer
//   hold_expired one-cycle pulse when a tenure is cut by the hold timer
//
// Handshake: req is a level; a requester keeps req high for as long as it
// wants the resource. Grant follows one cycle after arbitration, and the
// tenure ends on done, on req dropping, or on the hold limit. Every tenure
// is followed by at least one IDLE cycle in which arbitration re-runs.
module ring_rr_scheduler #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 8,
    parameter int IDW      = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           busy,
    output logic [N-1:0]   token,
    output logic           hold_expired
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state;
    logic [HW-1:0]  hold;

    logic [IDW-1:0] tok_idx;
    logic [IDW-1:0] win_idx;
    logic           win_found;
    logic [IDW:0]   scan_pos;
    logic           release_now;
    logic           timeout_cut;

    // Binary position of the one-hot token.
    always_comb begin
        tok_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (token[i]) tok_idx = IDW'(i);
        end
    end

    // Circular search: start at the token bit, walk upward, wrap at N.
    // The first set request encountered wins.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        scan_pos  = '0;
        for (int i = 0; i < N; i++) begin
            scan_pos = {1'b0, tok_idx} + (IDW+1)'(i);
            if (scan_pos >= (IDW+1)'(N)) scan_pos = scan_pos - (IDW+1)'(N);
            if (!win_found && req[scan_pos[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_pos[IDW-1:0];
            end
        end
    end

    // A timeout that coincides with done is an ordinary release, so the
    // pulse is only raised when the holder would otherwise have continued.
    assign release_now = done || !req[grant_id] || (hold == HW'(MAX_HOLD));
    assign timeout_cut = (hold == HW'(MAX_HOLD)) && !done && req[grant_id];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant        <= '0;
            grant_id     <= '0;
            busy         <= 1'b0;
            token        <= N'(1);
            hold         <= '0;
            hold_expired <= 1'b0;
        end else if (state == IDLE) begin
            hold_expired <= 1'b0;
            if (en && win_found) begin
                state    <= GRANT;
                grant    <= N'(1) << win_idx;
                grant_id <= win_idx;
                busy     <= 1'b1;
                hold     <= HW'(1);
            end
        end else begin
            if (release_now) begin
                state        <= IDLE;
                grant        <= '0;
                grant_id     <= '0;
                busy         <= 1'b0;
                hold         <= '0;
                // Priority passes to the requester just above the holder.
                token        <= {grant[N-2:0], grant[N-1]};
                hold_expired <= timeout_cut;
            end else begin
                hold_expired <= 1'b0;
                if (hold != HW'(MAX_HOLD)) hold <= hold + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ring_rr_scheduler.sv
module tb_ring_rr_scheduler;

    localparam int N        = 8;
    localparam int MAX_HOLD = 8;
    localparam int IDW      = 3;

    logic           clk;
    logic           rst_n;
    logic           en;
    logic [N-1:0]   req;
    logic           done;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic [N-1:0]   token;
    logic           hold_expired;

    ring_rr_scheduler #(.N(N), .MAX_HOLD(MAX_HOLD), .IDW(IDW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .req          (req),
        .done         (done),
        .grant        (grant),
        .grant_id     (grant_id),
        .busy         (busy),
        .token        (token),
        .hold_expired (hold_expired)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, need finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, need %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Holder kept as an integer index; token as an integer position.
    bit m_busy;
    int m_holder;
    int m_hold;
    int m_tok;
    bit m_hexp;

    function automatic void model_reset();
        m_busy = 0; m_holder = 0; m_hold = 0; m_tok = 0; m_hexp = 0;
    endfunction

    function automatic void model_step(input logic [N-1:0] r, input logic e, input logic d);
        if (!m_busy) begin
            m_hexp = 0;
            if (e && r != 0) begin
                for (int k = 0; k < N; k++) begin
                    if (r[(m_tok + k) % N]) begin
                        m_holder = (m_tok + k) % N;
                        break;
                    end
                end
                m_busy = 1;
                m_hold = 1;
            end
        end else if (d || !r[m_holder] || m_hold == MAX_HOLD) begin
            m_hexp = (m_hold == MAX_HOLD) && !d && r[m_holder];
            m_busy = 0;
            m_tok  = (m_holder + 1) % N;
            m_hold = 0;
        end else begin
            m_hexp = 0;
            m_hold++;
        end
    endfunction

    task automatic compare_all(input string tag);
        logic [N-1:0] eg;
        eg = m_busy ? (N'(1) << m_holder) : '0;
        check_eq({tag, ".grant"},    32'(grant), 32'(eg));
        check_eq({tag, ".grant_id"}, 32'(grant_id), m_busy ? 32'(m_holder) : 32'd0);
        check_eq({tag, ".busy"},     32'(busy), 32'(m_busy));
        check_eq({tag, ".token"},    32'(token), 32'(N'(1) << m_tok));
        check_eq({tag, ".hexp"},     32'(hold_expired), 32'(m_hexp));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input string tag);
        model_step(req, en, done);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- tests ----------------
    int n_grant;
    int n_hexp;

    initial begin
        rst_n = 1'b0; en = 1'b0; req = '0; done = 1'b0;

        // 1: reset values, single request, release via done
        do_reset();
        compare_all("t1_reset");
        check_eq("t1_reset_token", 32'(token), 32'h01);
        en = 1'b1; req = 8'h01;
        step("t1_grant");
        check_eq("t1_grant_val", 32'(grant), 32'h01);
        done = 1'b1;
        step("t1_release");
        check_eq("t1_token_after", 32'(token), 32'h02);

        // 2: all requesting, done held -> full rotation with wrap
        do_reset();
        req = 8'hFF; done = 1'b1; en = 1'b1;
        for (int b = 0; b <= N; b++) exp_q.push_back(N'(1) << (b % N));
        for (int c = 0; c < 2 * (N + 1); c++) begin
            step("t2");
            if (grant != 0) begin
                if (exp_q.size() == 0) check_eq("t2_extra_grant", 32'(grant), 32'h0);
                else check_eq("t2_order", 32'(grant), 32'(exp_q.pop_front()));
            end
        end
        check_eq("t2_queue_drained", 32'(exp_q.size()), 32'd0);

        // 3: single requester, no done -> hold timeout
        do_reset();
        req = 8'h10; done = 1'b0;
        n_grant = 0; n_hexp = 0;
        for (int c = 0; c < MAX_HOLD + 1; c++) begin
            step("t3");
            if (grant == 8'h10) n_grant++;
            if (hold_expired) n_hexp++;
        end
        check_eq("t3_tenure_len", 32'(n_grant), 32'(MAX_HOLD));
        check_eq("t3_hexp_count", 32'(n_hexp), 32'd1);
        step("t3_regrant");
        check_eq("t3_regrant_val", 32'(grant), 32'h10);

        // 4: wrap-around arbitration from token bit 6
        do_reset();
        req = 8'h20; done = 1'b0;
        step("t4_a");
        done = 1'b1;
        step("t4_b");
        check_eq("t4_token40", 32'(token), 32'h40);
        done = 1'b0; req = 8'h05;
        step("t4_c");
        check_eq("t4_wrap_id", 32'(grant_id), 32'd0);
        done = 1'b1;
        step("t4_d");
        check_eq("t4_token02", 32'(token), 32'h02);

        // 5: en dropped mid-tenure
        do_reset();
        req = 8'h01; done = 1'b0; en = 1'b1;
        step("t5_grant");
        en = 1'b0;
        for (int c = 0; c < 3; c++) step("t5_hold");
        check_eq("t5_still_busy", 32'(busy), 32'd1);
        done = 1'b1;
        step("t5_release");
        done = 1'b0; req = 8'hFF;
        for (int c = 0; c < 5; c++) step("t5_blocked");
        check_eq("t5_no_grant", 32'(grant), 32'h0);

        // 6: asynchronous reset in the middle of a tenure
        do_reset();
        en = 1'b1; req = 8'h02; done = 1'b0;
        step("t6_grant");
        step("t6_hold");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("t6_async_grant", 32'(grant), 32'h0);
        check_eq("t6_async_busy", 32'(busy), 32'd0);
        check_eq("t6_async_token", 32'(token), 32'h01);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        compare_all("t6_after");

        // 7: randomized traffic against the model
        do_reset();
        req = '0; en = 1'b1; done = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, (1 << N) - 1));
            en   = ($urandom_range(0, 7) != 0);
            done = ($urandom_range(0, 9) == 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
